nrisc_exec_ctrl: RTL and testbench
==================================

NRISC_EXEC_CTRL -- requirements
Module: nrisc_exec_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports exactly as follows:
- clk, input, 1 bit: rising-edge clock.
- rst_n, input, 1 bit: asynchronous active-low reset.
REQ-002 instr, input, 8 bits: instruction; [7:4] opcode, [3:2] rs, [1:0] rt/imm.
REQ-003 instrValid, input, 1 bit: instr is valid.
REQ-004 instrReady, output, 1 bit: block accepts instr this cycle.
REQ-005 readRegister1, output, 2 bits: register-file read address 1 (rs).
REQ-006 readRegister2, output, 2 bits: register-file read address 2 (rt).
REQ-007 readData1 and readData2, input, 8 bits each: register-file read data, valid before the next rising edge after the addresses are driven.
REQ-008 writeRegister, output, 3 bits: write address, always {1'b0, rs}.
REQ-009 writeData, output, 8 bits: write value.
REQ-010 writeEnable, output, 1 bit: register-file write strobe.
REQ-011 Status outputs:
- busy, output, 1 bit: asserted in any state except IDLE.
- zeroFlag, output, 1 bit: last written result was zero.
- carryFlag, output, 1 bit: carry from the last ADD/ADDI, or borrow from the last SUB.
- illegal, output, 1 bit: sticky flag for a reserved opcode.
- instrCount, output, 8 bits: number of retired instructions.

Function
REQ-012 FSM states: IDLE, READ, EXEC, WRITE; transitions on the rising edge of clk only.
REQ-013 IDLE: instrReady=1; on instrValid=1, latch instr and go to READ; otherwise stay in IDLE.
REQ-014 instrReady SHALL be 0 in READ, EXEC and WRITE; instrValid is ignored in those states.
REQ-015 READ: drive readRegister1=rs and readRegister2=rt from the latched instr; at the exiting edge, capture readData1/readData2 into operand registers A/B; go to EXEC.
REQ-016 readRegister1/2 SHALL hold their values from READ through WRITE.
REQ-017 EXEC: compute the result from A and B, register it at the exiting edge, then:
- go to WRITE for a writing opcode;
- go to IDLE for NOP or a reserved opcode.
REQ-018 Opcodes (8-bit, modulo 256):
- 0000 NOP.
- 0001 ADD: A+B.
- 0010 SUB: A-B.
- 0011 AND.
- 0100 OR.
- 0101 XOR.
- 0110 MOV: B.
- 0111 NOT: ~B.
- 1000 SHL: A<<1, zero fill.
- 1001 SHR: A>>1, logical.
- 1010 ADDI: A + sign-extended instr[1:0] (range -2..+1).
- 1011 CLR: 8'h00.
- 1100-1111: reserved.
REQ-019 carryFlag SHALL update only on ADD/ADDI (bit 8 of the 9-bit sum) and SUB (1 when A<B, unsigned); it holds otherwise.
REQ-020 zeroFlag SHALL update on every writing instruction to (result==0), at the EXEC exit edge.
REQ-021 WRITE: writeEnable=1 for exactly one cycle, with writeData=result and writeRegister={1'b0,rs}; go to IDLE.
REQ-022 writeEnable SHALL be 0 in every state other than WRITE; writeData holds the last result when writeEnable is low.
REQ-023 Latency: if accepted at edge N, writeEnable=1 during cycle N+2..N+3, the register file is written at edge N+3, and instrReady=1 again after edge N+3.
REQ-024 NOP and reserved opcodes SHALL return instrReady after edge N+2, with no write.
REQ-025 A reserved opcode SHALL set illegal=1; illegal stays set until reset, and execution continues normally.
REQ-026 instrCount SHALL increment by 1 when leaving EXEC for IDLE (NOP, reserved) or leaving WRITE; it wraps 255->0.
REQ-027 Source equal to destination (e.g. ADD r1,r1) SHALL use the pre-write operand values captured in READ.

Reset
REQ-028 While rst_n=0, asynchronously and independent of clk:
- state=IDLE, with instrReady=1, busy=0, writeEnable=0;
- writeData=0, writeRegister=0, readRegister1=0, readRegister2=0;
- zeroFlag=0, carryFlag=0, illegal=0, instrCount=0;
- operand and result registers cleared.
REQ-029 Reset asserted in any state, including WRITE, SHALL drop writeEnable immediately; the in-flight instruction is discarded and not counted.
REQ-030 After rst_n rises, the first instruction SHALL be accepted on the first rising edge at which instrValid=1.

Verification
REQ-031 The bench SHALL cover these directed scenarios:
- ADD with model r1=8'hF0, r2=8'h20, instr=8'h16 -> writeEnable pulses 1 cycle at N+2, writeRegister=3'd1, writeData=8'h10, carryFlag=1, zeroFlag=0, instrCount=1.
- SUB with r0=8'h05, instr=8'h20 (r0-r0) -> writeData=8'h00, zeroFlag=1, carryFlag=0.
- ADDI with r3=8'h00, instr=8'hAE (imm=2'b10=-2) -> writeData=8'hFE; SHR of 8'h81 -> 8'h40.
- Reserved opcode 8'hC5 -> no writeEnable, illegal=1, instrReady back after 2 edges; a following NOP keeps illegal=1 and instrCount=2.
- rst_n pulsed low during WRITE -> writeEnable=0 at once, instrCount unchanged at 0, instrReady=1.
- instrValid held high through 256 NOPs -> accept every 3 cycles, instrCount wraps to 0, instrReady=0 throughout READ/EXEC.

Source files
------------

// File: rtl/nrisc_exec_ctrl.sv
// nrisc_exec_ctrl: multi-cycle execute controller for a tiny 8-bit RISC.
// One instruction at a time walks IDLE -> READ -> EXEC -> (WRITE) -> IDLE.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   instr/instrValid/instrReady    instruction handshake ([7:4] op, [3:2] rs, [1:0] rt/imm)
//   readRegister1/2, readData1/2   register-file read port (rs, rt)
//   writeRegister/Data/Enable      register-file write port ({1'b0,rs})
//   busy, zeroFlag, carryFlag, illegal, instrCount   status
module nrisc_exec_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] instr,
  input  logic       instrValid,
  output logic       instrReady,
  output logic [1:0] readRegister1,
  output logic [1:0] readRegister2,
  input  logic [7:0] readData1,
  input  logic [7:0] readData2,
  output logic [2:0] writeRegister,
  output logic [7:0] writeData,
  output logic       writeEnable,
  output logic       busy,
  output logic       zeroFlag,
  output logic       carryFlag,
  output logic       illegal,
  output logic [7:0] instrCount
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WRITE} state_e;

  state_e     state_q, state_d;
  logic [7:0] instr_q, instr_d;
  logic [7:0] a_q, a_d, b_q, b_d;
  logic [7:0] result_q, result_d;
  logic       zero_q, zero_d, carry_q, carry_d, illegal_q, illegal_d;
  logic [7:0] count_q, count_d;

  // ALU decode of the latched instruction
  logic [3:0] op;
  logic [7:0] imm_ext;
  logic [8:0] sum9;
  logic [7:0] alu_res;
  logic       alu_writes, alu_reserved, carry_upd, carry_val;

  assign op      = instr_q[7:4];
  assign imm_ext = {{6{instr_q[1]}}, instr_q[1:0]};

  always_comb begin
    sum9         = '0;
    alu_res      = '0;
    alu_writes   = 1'b1;
    alu_reserved = 1'b0;
    carry_upd    = 1'b0;
    carry_val    = 1'b0;
    case (op)
      4'h0: alu_writes = 1'b0;
      4'h1: begin
        sum9      = {1'b0, a_q} + {1'b0, b_q};
        alu_res   = sum9[7:0];
        carry_upd = 1'b1;
        carry_val = sum9[8];
      end
      4'h2: begin
        alu_res   = a_q - b_q;
        carry_upd = 1'b1;
        carry_val = (a_q < b_q);  // borrow
      end
      4'h3: alu_res = a_q & b_q;
      4'h4: alu_res = a_q | b_q;
      4'h5: alu_res = a_q ^ b_q;
      4'h6: alu_res = b_q;
      4'h7: alu_res = ~b_q;
      4'h8: alu_res = {a_q[6:0], 1'b0};
      4'h9: alu_res = {1'b0, a_q[7:1]};
      4'hA: begin
        sum9      = {1'b0, a_q} + {1'b0, imm_ext};
        alu_res   = sum9[7:0];
        carry_upd = 1'b1;
        carry_val = sum9[8];
      end
      4'hB: alu_res = 8'h00;
      default: begin
        alu_writes   = 1'b0;
        alu_reserved = 1'b1;
      end
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (instrValid) state_d = S_READ;
      S_READ:  state_d = S_EXEC;
      S_EXEC:  state_d = alu_writes ? S_WRITE : S_IDLE;
      S_WRITE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // outputs decoded from state; read/write addresses come straight from the
  // latched instruction so they stay stable from READ through WRITE
  always_comb begin
    instrReady    = (state_q == S_IDLE);
    busy          = (state_q != S_IDLE);
    writeEnable   = (state_q == S_WRITE);
    readRegister1 = instr_q[3:2];
    readRegister2 = instr_q[1:0];
    writeRegister = {1'b0, instr_q[3:2]};
    writeData     = result_q;
    zeroFlag      = zero_q;
    carryFlag     = carry_q;
    illegal       = illegal_q;
    instrCount    = count_q;
  end

  // datapath next values
  always_comb begin
    instr_d   = instr_q;
    a_d       = a_q;
    b_d       = b_q;
    result_d  = result_q;
    zero_d    = zero_q;
    carry_d   = carry_q;
    illegal_d = illegal_q;
    count_d   = count_q;
    case (state_q)
      S_IDLE: if (instrValid) instr_d = instr;
      S_READ: begin
        // operands are frozen here, so rs==rd uses pre-write values
        a_d = readData1;
        b_d = readData2;
      end
      S_EXEC: begin
        if (alu_writes) begin
          result_d = alu_res;
          zero_d   = (alu_res == 8'h00);
        end else begin
          count_d = count_q + 8'd1;  // NOP/reserved retire here
        end
        if (carry_upd)    carry_d   = carry_val;
        if (alu_reserved) illegal_d = 1'b1;
      end
      S_WRITE: count_d = count_q + 8'd1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q   <= '0;
      a_q       <= '0;
      b_q       <= '0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      carry_q   <= 1'b0;
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else begin
      instr_q   <= instr_d;
      a_q       <= a_d;
      b_q       <= b_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      carry_q   <= carry_d;
      illegal_q <= illegal_d;
      count_q   <= count_d;
    end
  end

endmodule

// File: tb/tb_nrisc_exec_ctrl.sv
module tb_nrisc_exec_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] instr = 8'h00;
  logic       instrValid = 1'b0;
  logic       instrReady;
  logic [1:0] readRegister1, readRegister2;
  logic [7:0] readData1, readData2;
  logic [2:0] writeRegister;
  logic [7:0] writeData;
  logic       writeEnable, busy, zeroFlag, carryFlag, illegal;
  logic [7:0] instrCount;

  always #5 clk = ~clk;

  nrisc_exec_ctrl dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .instrValid(instrValid),
    .instrReady(instrReady), .readRegister1(readRegister1),
    .readRegister2(readRegister2), .readData1(readData1), .readData2(readData2),
    .writeRegister(writeRegister), .writeData(writeData),
    .writeEnable(writeEnable), .busy(busy), .zeroFlag(zeroFlag),
    .carryFlag(carryFlag), .illegal(illegal), .instrCount(instrCount)
  );

  // register-file model
  logic [7:0] rf [0:3];
  logic       pl_en = 1'b0;
  logic [1:0] pl_idx = 2'd0;
  logic [7:0] pl_val = 8'h00;
  assign readData1 = rf[readRegister1];
  assign readData2 = rf[readRegister2];
  always @(posedge clk) begin
    if (pl_en)            rf[pl_idx] <= pl_val;
    else if (writeEnable) rf[writeRegister[1:0]] <= writeData;
  end

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct packed {
    logic [2:0] wreg;
    logic [7:0] wdata;
    logic       c;
    logic       z;
  } exp_t;

  exp_t q[$];
  exp_t e;

  // monitor: every write strobe must match the oldest expected write
  always @(negedge clk) begin
    if (rst_n && writeEnable) begin
      if (q.size() == 0) begin
        chk("unexpected_write", {21'd0, writeEnable, writeRegister, writeData}, 32'd0);
      end else begin
        e = q.pop_front();
        chk("write", {writeRegister, writeData, carryFlag, zeroFlag},
            {e.wreg, e.wdata, e.c, e.z});
      end
    end
  end

  task automatic load(input logic [1:0] idx, input logic [7:0] val);
    @(negedge clk);
    pl_idx = idx; pl_val = val; pl_en = 1'b1;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    chk("reset_state",
        {instrReady, busy, writeEnable, zeroFlag, carryFlag, illegal, instrCount,
         writeData, writeRegister, readRegister1, readRegister2},
        {3'b100, 3'b000, 8'h00, 8'h00, 3'd0, 2'd0, 2'd0});
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // issue one instruction and check the cycle-by-cycle handshake
  task automatic run(input logic [7:0] ins, input logic wr, input exp_t ex);
    int w = 0;
    while (!instrReady && w < 50) begin @(negedge clk); w++; end
    chk("ready_before_issue", {31'd0, instrReady}, 32'd1);
    if (wr) q.push_back(ex);
    instr = ins; instrValid = 1'b1;
    @(posedge clk);
    #1;
    instrValid = 1'b0; instr = 8'hFF;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1)
        chk("read_cycle", {instrReady, writeEnable, busy, readRegister1, readRegister2},
            {3'b001, ins[3:0]});
      else if (k == 2)
        chk("exec_cycle", {instrReady, writeEnable, busy}, 3'b001);
      else if (k == 3)
        chk("third_cycle", {instrReady, writeEnable, busy}, wr ? 3'b011 : 3'b100);
      else
        chk("fourth_cycle", {instrReady, writeEnable, busy}, 3'b100);
      if (k == 3 && !wr) break;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    do_reset();
    load(2'd1, 8'hF0); load(2'd2, 8'h20); load(2'd0, 8'h05); load(2'd3, 8'h00);

    // directed arithmetic
    run(8'h16, 1'b1, exp_t'{3'd1, 8'h10, 1'b1, 1'b0});  // ADD r1,r2
    chk("add_count", instrCount, 8'd1);
    chk("add_rf", rf[1], 8'h10);
    run(8'h20, 1'b1, exp_t'{3'd0, 8'h00, 1'b0, 1'b1});  // SUB r0,r0
    run(8'hAE, 1'b1, exp_t'{3'd3, 8'hFE, 1'b0, 1'b0});  // ADDI r3,-2
    load(2'd2, 8'h81);
    run(8'h98, 1'b1, exp_t'{3'd2, 8'h40, 1'b0, 1'b0});  // SHR r2
    chk("count4", instrCount, 8'd4);

    // logic ops, borrow, carry hold
    load(2'd0, 8'hC3); load(2'd1, 8'h5A);
    run(8'h31, 1'b1, exp_t'{3'd0, 8'h42, 1'b0, 1'b0});  // AND
    run(8'h41, 1'b1, exp_t'{3'd0, 8'h5A, 1'b0, 1'b0});  // OR
    run(8'h51, 1'b1, exp_t'{3'd0, 8'h00, 1'b0, 1'b1});  // XOR
    run(8'h27, 1'b1, exp_t'{3'd1, 8'h5C, 1'b1, 1'b0});  // SUB borrow
    run(8'h67, 1'b1, exp_t'{3'd1, 8'hFE, 1'b1, 1'b0});  // MOV, carry holds
    run(8'h77, 1'b1, exp_t'{3'd1, 8'h01, 1'b1, 1'b0});  // NOT
    run(8'h8C, 1'b1, exp_t'{3'd3, 8'hFC, 1'b1, 1'b0});  // SHL
    run(8'hA5, 1'b1, exp_t'{3'd1, 8'h02, 1'b0, 1'b0});  // ADDI +1
    run(8'hB2, 1'b1, exp_t'{3'd0, 8'h00, 1'b0, 1'b1});  // CLR
    chk("count13", instrCount, 8'd13);

    // reserved opcode, then NOP
    do_reset();
    run(8'hC5, 1'b0, '0);
    chk("illegal_set", {31'd0, illegal}, 32'd1);
    run(8'h00, 1'b0, '0);
    chk("illegal_sticky_count", {illegal, instrCount}, {1'b1, 8'd2});

    // reset in the middle of WRITE
    do_reset();
    instr = 8'h16; instrValid = 1'b1;
    @(posedge clk);
    #1 instrValid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 chk("mid_write_we", {31'd0, writeEnable}, 32'd1);
    rst_n = 1'b0;
    #1 chk("mid_write_reset", {instrReady, busy, writeEnable, instrCount}, {3'b100, 8'd0});
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_write_no_rf_update", rf[1], 8'h02);

    // instrValid held high through 256 NOPs
    begin
      int errs = 0;
      @(negedge clk);
      instr = 8'h00; instrValid = 1'b1;
      for (int i = 0; i < 768; i++) begin
        if (instrReady !== ((i % 3) == 0) || busy === instrReady || writeEnable !== 1'b0) errs++;
        if (i == 766) instrValid = 1'b0;
        if (i == 767) chk("nop_count_255", instrCount, 8'd255);
        @(negedge clk);
      end
      chk("nop_pattern_errors", errs, 32'd0);
      chk("nop_wrap", {instrReady, instrCount}, {1'b1, 8'd0});
    end

    chk("scoreboard_empty", q.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
